wb_arbiter_2m: RTL
==================

// Module: wb_arbiter_2m
// PURPOSE
//  Shares one Wishbone pipelined slave port (e.g. a generated register block or its submap bus)
//  between two Wishbone pipelined masters. Arbitration is round-robin.
//  One transaction is outstanding at a time. A timeout converts a hung slave into m_err_o.
//  Sits between CPU/DMA masters and a generated register map.
// PARAMETERS
//  AW       2   slave address width in bits; word address, bits [AW+1:2]
//  DW      32   data width; sel width is DW/8
//  TIMEOUT 255  cycles to wait for slave ack/err before forcing err; 0 disables, 8-bit counter
// PORTS
//  clk_i      in   1        clock; all logic on rising edge
//  rst_i      in   1        synchronous, active-high reset
//  m_cyc_i    in   2        per-master cyc; bit i = master i
//  m_stb_i    in   2        per-master stb
//  m_we_i     in   2        per-master write enable
//  m_sel_i    in   2*DW/8   per-master byte select; master i in slice [i*DW/8 +: DW/8]
//  m_adr_i    in   2*AW     per-master address; slice [i*AW +: AW]
//  m_dat_i    in   2*DW     per-master write data; slice [i*DW +: DW]
//  m_ack_o    out  2        per-master ack; 1-cycle pulse
//  m_err_o    out  2        per-master err; 1-cycle pulse, on slave err or timeout
//  m_stall_o  out  2        per-master stall
//  m_dat_o    out  DW       read data; shared, valid when the owning master's ack is high
//  s_cyc_o / s_stb_o / s_we_o   out  1     slave cycle, strobe, write enable
//  s_sel_o    out  DW/8     slave byte select
//  s_adr_o    out  AW       slave address
//  s_dat_o    out  DW       slave write data
//  s_ack_i / s_err_i / s_stall_i   in  1   slave ack, err, stall
//  s_dat_i    in   DW       slave read data
//  gnt_o      out  2        one-hot current owner; 0 when idle
// BEHAVIOUR
//  Reset: state IDLE, rr pointer -> master 0, gnt_o = 0.
//   s_cyc/stb/we/sel/adr/dat = 0; m_ack = m_err = 0; m_stall_o = 2'b11 while requesting.
//  req[i] = m_cyc_i[i] & m_stb_i[i].
//  FSM IDLE -> ISSUE -> WAIT -> IDLE.
//  IDLE, no request: m_stall_o[i] = req[i], so both are 0.
//  IDLE, grant:
//   - Winner: the sole requester. If both request, the master the rr pointer names.
//   - In the grant cycle: m_stall_o[winner] = 0; the loser stays stalled.
//   - Winner's we/sel/adr/dat are latched into output registers; gnt_o is set.
//   - rr pointer -> the other master; state -> ISSUE.
//  ISSUE: s_cyc_o = s_stb_o = 1. If s_stall_i = 0: -> WAIT (stb drops next cycle); else hold.
//  WAIT: s_cyc_o = 1, s_stb_o = 0.
//  Completion, in ISSUE (stall = 0) or WAIT:
//   - s_ack_i gives m_ack_o[g] = 1 in the same cycle (combinational).
//   - s_err_i gives m_err_o[g] = 1 in the same cycle (combinational).
//   - m_dat_o = s_dat_i. Next state IDLE; gnt_o cleared.
//  Latency: request accepted in cycle N; s_stb_o high in N+1; ack passes with 0 added cycles.
//   Minimum 3 cycles per transfer.
//  Ack and err together: err wins; ack is suppressed.
//  Timeout: counter clears on grant and increments each cycle in ISSUE/WAIT.
//   When it reaches TIMEOUT with no ack/err: m_err_o[g] pulses 1 cycle, s_cyc_o drops, -> IDLE.
//   A late s_ack_i in IDLE is ignored.
//  Abort: m_cyc_i[g] falls in ISSUE/WAIT: s_cyc_o drops next cycle, -> IDLE, no ack/err to g.
//  Non-owner: m_ack_o and m_err_o always 0; m_stall_o = req.
//  Reset mid-transaction: everything returns to reset values next cycle. The slave sees cyc drop.
// STRUCTURE
//  Shared include wb_arb_defs.vh:
//   - state localparams ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2
//   - TIMEOUT counter width localparam (8)
//  Sub-module rr_arbiter_2: req[1:0], advance -> one-hot gnt[1:0], pointer register.
//   Reused by future N-master versions.
// TESTING
//  T1 Reset: rst_i = 1 for 2 cycles while both masters request -> all s_* = 0, gnt_o = 0,
//     m_stall_o = 2'b11.
//  T2 Single write: M0 writes adr = 1, dat = 0xDEADBEEF, sel = 0xF; slave acks 2 cycles after stb
//     -> s_stb_o high exactly 1 cycle, m_ack_o = 2'b01 one cycle, M1 untouched.
//  T3 Contention: both masters read every cycle for 6 transfers
//     -> grant order 0,1,0,1,0,1; m_dat_o matches s_dat_i on each ack.
//  T4 Stall: s_stall_i = 1 for 4 cycles in ISSUE -> s_stb_o held 5 cycles, then exactly one ack.
//  T5 Timeout: TIMEOUT = 8, slave never acks -> m_err_o[g] pulses 8 cycles after grant,
//     s_cyc_o low next cycle; a late s_ack_i is ignored.
//  T6 Abort/err: M1 drops cyc in WAIT -> no ack, IDLE; slave asserts ack+err together
//     -> only m_err_o pulses.

Source files
------------

// File: rtl/wb_arbiter_2m_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
// Holds the FSM state encoding, the timeout counter width and the
// round-robin pick function.
package wb_arbiter_2m_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

   // Width of the slave-response timeout counter
   localparam int unsigned TMO_CW = 8;

   // One-hot winner for two requesters.
   // If both masters request, ptr names the winner (0 -> master 0, 1 -> master 1).
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
      logic [1:0] pick;
      case (req)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = ptr ? 2'b10 : 2'b01;
         default: pick = 2'b00;
      endcase
      return pick;
   endfunction

endpackage

// File: rtl/wb_arbiter_2m_rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter.
// The grant is combinational from req and the pointer. On advance, the
// pointer moves to the master that did not win, so that master is
// favoured on the next tie.
module rr_arbiter_2
   import wb_arbiter_2m_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic ptr;

   // Winner selection from the current requests and the pointer
   always_comb begin
      gnt = rr_pick(req, ptr);
   end

   // Pointer update: after a grant, point at the other master
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (advance && (gnt != 2'b00)) begin
         ptr <= gnt[0];
      end
   end

endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: shares one Wishbone pipelined slave port between two
// pipelined masters using round-robin arbitration. Only one transaction
// is outstanding at a time; a hung slave is turned into m_err_o after
// TIMEOUT cycles (TIMEOUT = 0 disables the timeout).
module wb_arbiter_2m
   import wb_arbiter_2m_pkg::*;
#(
   parameter int unsigned AW      = 2,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [1:0]          m_cyc_i,
   input  logic [1:0]          m_stb_i,
   input  logic [1:0]          m_we_i,
   input  logic [2*DW/8-1:0]   m_sel_i,
   input  logic [2*AW-1:0]     m_adr_i,
   input  logic [2*DW-1:0]     m_dat_i,
   output logic [1:0]          m_ack_o,
   output logic [1:0]          m_err_o,
   output logic [1:0]          m_stall_o,
   output logic [DW-1:0]       m_dat_o,
   output logic                s_cyc_o,
   output logic                s_stb_o,
   output logic                s_we_o,
   output logic [DW/8-1:0]     s_sel_o,
   output logic [AW-1:0]       s_adr_o,
   output logic [DW-1:0]       s_dat_o,
   input  logic                s_ack_i,
   input  logic                s_err_i,
   input  logic                s_stall_i,
   input  logic [DW-1:0]       s_dat_i,
   output logic [1:0]          gnt_o
);

   localparam int unsigned SW = DW / 8;
   localparam bit          TMO_EN = (TIMEOUT != 0);
   // Counter value in the cycle that is TIMEOUT cycles after the grant cycle
   localparam logic [TMO_CW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TMO_CW'(TIMEOUT - 1);

   arb_state_t        state;
   logic [TMO_CW-1:0] tmo_cnt;
   logic [1:0]        req;
   logic [1:0]        rr_gnt;
   logic              grant;
   logic              busy;
   logic              owner_cyc;
   logic              rsp_ok;
   logic              fin_ack;
   logic              fin_err;
   logic              fin_tmo;
   logic              abort;
   logic              xfer_end;

   assign req = m_cyc_i & m_stb_i;

   rr_arbiter_2 u_rr (
      .clk     (clk_i),
      .rst     (rst_i),
      .req     (req),
      .advance (grant),
      .gnt     (rr_gnt)
   );

   // Transaction decode: grant, completion, timeout and abort conditions
   always_comb begin
      busy      = (state != ST_IDLE);
      grant     = (state == ST_IDLE) && !rst_i && (req != 2'b00);
      owner_cyc = |(gnt_o & m_cyc_i);
      // A response only counts once the strobe has been accepted
      rsp_ok    = (state == ST_WAIT) || ((state == ST_ISSUE) && !s_stall_i);
      fin_err   = busy && owner_cyc && rsp_ok && s_err_i;
      fin_ack   = busy && owner_cyc && rsp_ok && s_ack_i && !s_err_i;
      fin_tmo   = busy && owner_cyc && TMO_EN && (tmo_cnt == TMO_LAST) && !fin_err && !fin_ack;
      abort     = busy && !owner_cyc;
      xfer_end  = fin_ack || fin_err || fin_tmo || abort;
   end

   // Route slave responses to the owning master in the same cycle
   always_comb begin
      m_ack_o = '0;
      m_err_o = '0;
      if (!rst_i) begin
         if (fin_ack) begin
            m_ack_o = gnt_o;
         end
         if (fin_err || fin_tmo) begin
            m_err_o = gnt_o;
         end
      end
   end

   // Every requester is stalled except the winner in its grant cycle
   always_comb begin
      m_stall_o = grant ? (req & ~rr_gnt) : req;
   end

   assign m_dat_o = s_dat_i;

   // Arbiter FSM with registered slave-side outputs and grant
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         s_cyc_o <= 1'b0;
         s_stb_o <= 1'b0;
         s_we_o  <= 1'b0;
         s_sel_o <= '0;
         s_adr_o <= '0;
         s_dat_o <= '0;
         gnt_o   <= '0;
         tmo_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  state   <= ST_ISSUE;
                  s_cyc_o <= 1'b1;
                  s_stb_o <= 1'b1;
                  gnt_o   <= rr_gnt;
                  tmo_cnt <= '0;
                  s_we_o  <= rr_gnt[1] ? m_we_i[1]         : m_we_i[0];
                  s_sel_o <= rr_gnt[1] ? m_sel_i[SW +: SW] : m_sel_i[0 +: SW];
                  s_adr_o <= rr_gnt[1] ? m_adr_i[AW +: AW] : m_adr_i[0 +: AW];
                  s_dat_o <= rr_gnt[1] ? m_dat_i[DW +: DW] : m_dat_i[0 +: DW];
               end
            end
            ST_ISSUE, ST_WAIT: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (xfer_end) begin
                  state   <= ST_IDLE;
                  s_cyc_o <= 1'b0;
                  s_stb_o <= 1'b0;
                  gnt_o   <= '0;
               end else if ((state == ST_ISSUE) && !s_stall_i) begin
                  state   <= ST_WAIT;
                  s_stb_o <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               s_cyc_o <= 1'b0;
               s_stb_o <= 1'b0;
               gnt_o   <= '0;
            end
         endcase
      end
   end

endmodule
